// File: rtl/phase_strobe_seq.sv
// One-hot instruction-phase sequencer with stall/halt and a completed-cycle counter.
// Optional single-step start is enabled by defining SEQ_STEP_EN (adds the `step` port).
module phase_strobe_seq #(
    parameter int NPHASE = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic                      halt,
`ifdef SEQ_STEP_EN
    input  logic                      step,
`endif
    output logic [NPHASE-1:0]         phase_en,
    output logic [$clog2(NPHASE)-1:0] phase,
    output logic                      running,
    output logic                      cycle_done,
    output logic [CNT_W-1:0]          cycles
);
    localparam int PW = $clog2(NPHASE);
    localparam logic [PW-1:0]     LAST = PW'(NPHASE - 1);
    localparam logic [NPHASE-1:0] ONE  = NPHASE'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              cycle_done_q, cycle_done_d;
    logic [NPHASE-1:0] phase_en_q;
    logic              step_w;

`ifdef SEQ_STEP_EN
    assign step_w = step;
`else
    assign step_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            halt_pend_q  <= 1'b0;
            cycles_q     <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            halt_pend_q  <= halt_pend_d;
            cycles_q     <= cycles_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        halt_pend_d  = halt_pend_q;
        cycles_d     = cycles_q;
        cycle_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    phase_d     = '0;
                    // A single-step start behaves like a halt latched on entry.
                    halt_pend_d = step_w;
                end
            end
            S_RUN: begin
                if (halt) halt_pend_d = 1'b1;
                if (stall) begin
                    state_d = S_HOLD;
                end else if (phase_q != LAST) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d      = '0;
                    cycles_d     = cycles_q + 1'b1;
                    cycle_done_d = 1'b1;
                    if (halt_pend_q || halt) begin
                        state_d     = S_IDLE;
                        halt_pend_d = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (halt) halt_pend_d = 1'b1;
                if (!stall) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Falling-edge retime keeps each enable stable half a clock around its strobe edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) phase_en_q <= '0;
        else     phase_en_q <= (state_q == S_RUN) ? (ONE << phase_q) : '0;
    end

    assign phase_en   = phase_en_q;
    assign phase      = phase_q;
    assign running    = (state_q == S_RUN) || (state_q == S_HOLD);
    assign cycle_done = cycle_done_q;
    assign cycles     = cycles_q;
endmodule
